// File: rtl/mem_result_checker_if.sv
// mem_result_checker_if: shared read port from the checker to the data memory and answer ROM
interface mem_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ans_rdata;
  modport master (output rd_addr, rd_en, input mem_rdata, ans_rdata);
  modport slave  (input rd_addr, rd_en, output mem_rdata, ans_rdata);
endinterface

// File: rtl/mem_result_checker.sv
// mem_result_checker: post-run scan comparing data memory against an answer ROM under a bit mask
module mem_result_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int PC_W   = 32,
  parameter int END_PC = 128,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic [PC_W-1:0]     pc,
  input  logic [DATA_W-1:0]   cmp_mask,
  mem_result_checker_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    error_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_got,
  output logic [DATA_W-1:0]   err_exp
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam logic [PC_W-1:0]   END_ADDR = PC_W'(END_PC);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  state_t            state;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mis;
  logic [CNT_W-1:0]  cnt_next;
  always_comb begin
    mis      = cmp_valid && |((bus.mem_rdata ^ bus.ans_rdata) & cmp_mask);
    cnt_next = error_count + CNT_W'(mis && !(&error_count));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.rd_addr     <= '0;
      bus.rd_en       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      err_valid       <= 1'b0;
      err_addr        <= '0;
      err_got         <= '0;
      err_exp         <= '0;
      cmp_valid       <= 1'b0;
      cmp_addr        <= '0;
    end else if (clear) begin
      state           <= IDLE;
      bus.rd_addr     <= '0;
      bus.rd_en       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      err_valid       <= 1'b0;
      err_addr        <= '0;
      err_got         <= '0;
      err_exp         <= '0;
      cmp_valid       <= 1'b0;
      cmp_addr        <= '0;
    end else begin
      cmp_valid <= bus.rd_en;
      cmp_addr  <= bus.rd_addr;
      err_valid <= mis;
      if (mis) begin
        err_addr    <= cmp_addr;
        err_got     <= bus.mem_rdata;
        err_exp     <= bus.ans_rdata;
        error_count <= cnt_next;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= cmp_addr;
        end
      end
      case (state)
        IDLE: if (en && pc >= END_ADDR) begin
          state       <= SCAN;
          bus.rd_addr <= '0;
          bus.rd_en   <= 1'b1;
          busy        <= 1'b1;
        end
        SCAN: if (bus.rd_addr == LAST) begin
          state     <= DRAIN;
          bus.rd_en <= 1'b0;
        end else begin
          bus.rd_addr <= bus.rd_addr + 1'b1;
        end
        // last address is compared this cycle, so pass sees the final count
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= cnt_next == '0;
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_result_checker.sv
// tb_mem_result_checker: scoreboard bench for the memory result checker (default and 2-bit counter instances)
module tb_mem_result_checker;
  logic clk = 0, rst = 0, en = 0, clear = 0;
  logic [31:0] pc = 0, cmp_mask = '1;
  logic busy, done, pass, first_err_valid, err_valid;
  logic [7:0] error_count;
  logic [5:0] first_err_addr, err_addr;
  logic [31:0] err_got, err_exp;
  logic busy2, done2, pass2, fev2, ev2;
  logic [1:0] error_count2;
  logic [5:0] fea2, ea2;
  logic [31:0] eg2, ee2;
  logic [31:0] mem [64];
  logic [31:0] ans [64];
  int errors = 0, checks = 0, strobes2 = 0;
  typedef struct {logic [5:0] a; logic [31:0] g; logic [31:0] e;} ev_t;
  ev_t q[$];
  ev_t x;

  always #5 clk = ~clk;

  mem_result_checker_if #(.DATA_W(32), .ADDR_W(6)) bus ();
  mem_result_checker_if #(.DATA_W(32), .ADDR_W(6)) bus2 ();

  mem_result_checker dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .pc(pc), .cmp_mask(cmp_mask), .bus(bus.master),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
    .err_valid(err_valid), .err_addr(err_addr), .err_got(err_got), .err_exp(err_exp));

  mem_result_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .pc(pc), .cmp_mask(cmp_mask), .bus(bus2.master),
    .busy(busy2), .done(done2), .pass(pass2), .error_count(error_count2),
    .first_err_valid(fev2), .first_err_addr(fea2),
    .err_valid(ev2), .err_addr(ea2), .err_got(eg2), .err_exp(ee2));

  always @(posedge clk) if (bus.rd_en) begin
    bus.mem_rdata <= mem[bus.rd_addr];
    bus.ans_rdata <= ans[bus.rd_addr];
  end
  always @(posedge clk) if (bus2.rd_en) begin
    bus2.mem_rdata <= mem[bus2.rd_addr];
    bus2.ans_rdata <= ans[bus2.rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err_valid) begin
      check("strobe_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        x = q.pop_front();
        check("err_addr", err_addr, x.a);
        check("err_got", err_got, x.g);
        check("err_exp", err_exp, x.e);
      end
    end
    if (ev2) strobes2++;
    if (bus.rd_en) check("rd_en_only_when_busy", busy, 1);
  end

  task automatic load_exp(output int n, output logic fv, output logic [5:0] fa);
    n = 0; fv = 0; fa = 0;
    for (int i = 0; i < 64; i++)
      if (((mem[i] ^ ans[i]) & cmp_mask) != 0) begin
        q.push_back('{a: 6'(i), g: mem[i], e: ans[i]});
        if (!fv) begin fv = 1; fa = 6'(i); end
        n++;
      end
  endtask

  task automatic run_scan(input logic [31:0] mask, input bit step);
    int n, lat, s0;
    logic fv;
    logic [5:0] fa;
    cmp_mask = mask;
    load_exp(n, fv, fa);
    s0 = strobes2;
    clear = 0;
    en = 1;
    if (step) begin
      pc = 32'h7C;
      @(posedge clk); #1;
      check("no_trigger_below_end", busy, 0);
      @(negedge clk);
      pc = 32'h80;
    end
    @(posedge clk); #1;
    check("trigger_busy", busy, 1);
    check("trigger_rd_en", bus.rd_en, 1);
    check("trigger_rd_addr", bus.rd_addr, 0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); lat++; #1;
    end
    check("latency", lat, 65);
    check("busy_at_done", busy, 0);
    check("pass", pass, n == 0);
    check("error_count", error_count, n);
    check("first_err_valid", first_err_valid, fv);
    check("first_err_addr", first_err_addr, fa);
    check("error_count_sat", error_count2, n > 3 ? 3 : n);
    check("pass_sat", pass2, n == 0);
    @(negedge clk); #1;
    check("strobes_missing", q.size(), 0);
    check("strobes_sat", strobes2 - s0, n);
    en = 0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1;
    @(posedge clk); #1;
    check("clear_done", done, 0);
    check("clear_busy", busy, 0);
    check("clear_pass", pass, 0);
    check("clear_count", error_count, 0);
    check("clear_first_valid", first_err_valid, 0);
    check("clear_first_addr", first_err_addr, 0);
    @(negedge clk);
    clear = 0;
  endtask

  task automatic fill_equal();
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ans[i] = mem[i];
    end
  endtask

  initial begin
    fill_equal();
    #2 rst = 1;
    @(negedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_count", error_count, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_got", err_got, 0);
    rst = 0;
    run_scan(32'hFFFF_FFFF, 1);

    do_clear();
    mem[5] = 32'h1234; ans[5] = 32'h1235;
    mem[40] = ans[40] ^ 32'h8000_0000;
    run_scan(32'hFFFF_FFFF, 1);

    do_clear();
    fill_equal();
    mem[7] = ans[7] ^ 32'h1;
    run_scan(32'hFFFF_FFFE, 0);

    do_clear();
    for (int i = 0; i < 64; i++) ans[i] = ~mem[i];
    run_scan(32'hFFFF_FFFF, 0);

    do_clear();
    fill_equal();
    mem[5] = 32'h1234; ans[5] = 32'h1235;
    mem[40] = ans[40] ^ 32'h0001_0000;
    begin
      int n;
      logic fv;
      logic [5:0] fa;
      cmp_mask = '1;
      load_exp(n, fv, fa);
      en = 1; pc = 32'h80;
      for (int i = 0; i < 100 && !(busy && bus.rd_addr == 30); i++) @(negedge clk);
      check("reach_addr30", bus.rd_addr, 30);
      rst = 1; #1;
      check("abort_busy", busy, 0);
      check("abort_rd_en", bus.rd_en, 0);
      check("abort_rd_addr", bus.rd_addr, 0);
      check("abort_count", error_count, 0);
      check("abort_first_valid", first_err_valid, 0);
      check("abort_done", done, 0);
      q.delete();
      en = 0;
      @(negedge clk);
      rst = 0;
    end
    run_scan(32'hFFFF_FFFF, 1);

    do_clear();
    en = 0; pc = 32'h80;
    repeat (5) @(posedge clk);
    #1;
    check("en0_busy", busy, 0);
    check("en0_rd_en", bus.rd_en, 0);
    check("en0_done", done, 0);

    run_scan(32'hFFFF_FFFF, 0);
    en = 1; pc = 32'h80;
    do_clear();
    check("clear_no_retrigger", busy, 0);
    run_scan(32'hFFFF_FFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_result_checker.md
# mem_result_checker

Synthesizable self-checking result scanner for the single-cycle ARM core's simulation and FPGA bring-up. Once the program counter passes a programmable end address, it walks every word of the data memory and compares each against an expected-answer memory. Each comparison goes through a per-bit mask. It accumulates an error count, latches the first mismatch, and emits a per-mismatch log strobe. It sits beside the core, with its own read ports on the data memory and the answer ROM, and replaces end-of-run memory scanning done in the testbench.

## Interface
- DATA_W, 32, width of data and answer words
- DEPTH, 64, number of words scanned (addresses 0..DEPTH-1)
- ADDR_W, 6, word-address width (must satisfy 2^ADDR_W >= DEPTH)
- PC_W, 32, program-counter width
- END_PC, 128, byte address at which the scan triggers (32 instructions × 4)
- CNT_W, 8, error-counter width (saturating)

- clk, in, 1, rising-edge clock
- rst, in, 1, asynchronous active-high reset
- en, in, 1, arms the trigger; ignored outside IDLE
- clear, in, 1, synchronous abort/restart to IDLE; clears all results
- pc, in, PC_W, core program counter
- cmp_mask, in, DATA_W, bit i = 1 means bit i is compared; must be held stable during a scan
- rd_addr, out, ADDR_W, shared word address to data memory and answer memory
- rd_en, out, 1, read enable to both memories
- mem_rdata, in, DATA_W, data-memory word (synchronous read, 1-cycle latency)
- ans_rdata, in, DATA_W, answer word (synchronous read, 1-cycle latency)
- busy, out, 1, scan in progress
- done, out, 1, sticky: scan finished
- pass, out, 1, valid when done: 1 when error_count == 0
- error_count, out, CNT_W, mismatches so far; saturates at all-ones
- first_err_valid, out, 1, sticky: at least one mismatch seen
- first_err_addr, out, ADDR_W, address of the first mismatch
- err_valid, out, 1, one-cycle strobe per mismatch
- err_addr / err_got / err_exp, out, ADDR_W/DATA_W/DATA_W, payload of the strobe (raw unmasked words)

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: when en=1 and pc >= END_PC (unsigned) at an edge, go to SCAN with rd_addr=0, rd_en=1, busy=1.
- SCAN: rd_addr increments by 1 each cycle. After issuing DEPTH-1, go to DRAIN with rd_en=0.
- DRAIN: one cycle, so the last issued address is compared. Then go to DONE with busy=0, done=1.
- DONE: holds all results until rst or clear. pc and en are ignored.
- Compare stage: a registered cmp_valid/cmp_addr pair trails rd_en/rd_addr by one cycle. A mismatch is ((mem_rdata ^ ans_rdata) & cmp_mask) != 0.
- On a mismatch:
  - error_count increments, holding once it reaches all-ones.
  - If first_err_valid=0, latch first_err_addr and set first_err_valid.
  - Register err_valid=1 with err_addr, err_got, err_exp.
- If cmp_mask = 0, every word matches and pass=1.
- clear has priority over every state transition. It returns the block to IDLE with all outputs at reset values and does not retrigger in the same cycle.
- rst mid-scan: immediate return to IDLE. Partial results are discarded.

## Timing
- Reset values: state IDLE; rd_addr=0, rd_en=0, busy=0, done=0, pass=0, error_count=0, first_err_valid=0, first_err_addr=0, err_valid=0, err_addr=0, err_got=0, err_exp=0.
- Trigger edge = E0. Address k is presented during the cycle after edge E(k).
- Its compare result is registered at edge E(k+2), so err_valid for address k is high in the cycle after E(k+2).
- done rises at edge E(DEPTH+1). Total latency from trigger to done is DEPTH+1 cycles (65 for the defaults).
- pass is registered together with done, from the final count including the last compare.
- err_valid is high for exactly one cycle per mismatch. Back-to-back mismatches give consecutive strobes.
- Memories must present read data one cycle after rd_en/rd_addr. rd_en is never asserted outside SCAN.

## Test plan
- All 64 words equal, cmp_mask=FFFFFFFF, pc steps to 0x80 with en=1 -> done exactly 65 cycles after trigger, pass=1, error_count=0, no err_valid pulse.
- mem[5]=0x1234 vs ans[5]=0x1235, plus mem[40] wrong -> error_count=2; first_err_addr=5; two strobes with err_addr 5 then 40; err_got=0x1234, err_exp=0x1235 on the first.
- mem[7] differs only in bit 0, cmp_mask=FFFFFFFE -> pass=1, error_count=0.
- CNT_W=2, all 64 words mismatched -> error_count saturates at 3, strobes continue for 64 cycles, pass=0.
- rst asserted at scan address 30, then released -> outputs at reset values immediately. A new trigger rescans from 0 and gives correct results.
- en=0 with pc=0x80 -> stays IDLE. clear pulsed during DONE -> done=0, results cleared. Re-raising en with pc still >= 0x80 starts a fresh scan.
